mem_bus_ctrl: RTL and testbench

Memory bus controller between the multicycle control unit and the unified instruction/data memory bus. It turns single-cycle memRead/memWrite strobes into a req/ack bus transaction. It handles byte-lane steering, store data replication and load sign/zero extension, and flags misaligned accesses, bus errors and timeouts. Its sticky `error` output feeds the control unit's `error` input to halt the core.

---
 rtl/mem_bus_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Bridges the multicycle control unit's single-cycle memRead/memWrite
//   strobes onto a req/ack memory bus. It validates each request, steers
//   byte lanes and replicates store data, formats load data with sign or
//   zero extension, and raises a sticky error on misalignment, an illegal
//   funct3, a slave error or a timeout.
//
// Parameters
//   TIMEOUT    max cycles bus_req may stay high without ack (0 = never)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   memRead, memWrite   one-cycle request strobes
//   isInstr             instruction fetch: forces a word load
//   addr, wdata         byte address, store data (rs2)
//   funct3              RISC-V load/store size/sign encoding
//   rdata               formatted load data, held until the next read
//   busy                transaction in flight (decoded from state)
//   done                one-cycle completion pulse
//   error               sticky fault, cleared only by rst
//   bus_req, bus_we     bus request / write enable
//   bus_addr, bus_be    word-aligned address, byte enables
//   bus_wdata           lane-steered store data
//   bus_rdata           bus read data
//   bus_ack, bus_err    transfer complete / slave error
module mem_bus_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        isInstr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  // Wait counter is at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int              CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Decoded form of an incoming request, registered on acceptance.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [1:0]  off;
  } req_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic       req_rd, req_wr, req_both;
  logic [2:0] f3_eff;
  logic       legal_f3, misal, req_ok;
  req_t       dec;

  always_comb begin
    req_rd   = memRead & ~memWrite;
    req_wr   = memWrite & ~memRead;
    req_both = memRead & memWrite;
    // Fetches always behave as LW regardless of funct3.
    f3_eff   = isInstr ? 3'b010 : funct3;

    // Unsigned variants exist only for loads.
    legal_f3 = 1'b0;
    case (f3_eff)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = req_rd;
      default:                legal_f3 = 1'b0;
    endcase

    misal = 1'b0;
    case (f3_eff[1:0])
      2'b01:   misal = addr[0];
      2'b10:   misal = (addr[1:0] != 2'b00);
      default: misal = 1'b0;
    endcase

    req_ok = legal_f3 & ~misal;

    dec       = '0;
    dec.we    = req_wr;
    dec.addr  = {addr[31:2], 2'b00};
    dec.f3    = f3_eff;
    dec.off   = addr[1:0];
    case (f3_eff[1:0])
      2'b00: begin
        dec.be    = 4'b0001 << addr[1:0];
        dec.wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        dec.be    = 4'b0011 << {addr[1], 1'b0};
        dec.wdata = {2{wdata[15:0]}};
      end
      default: begin
        dec.be    = 4'b1111;
        dec.wdata = wdata;
      end
    endcase
    // Reads drive no store data onto the bus.
    if (!req_wr) dec.wdata = '0;
  end

  // ---------------------------------------------------------------------
  // Load formatting, using the lane offset captured with the request
  // ---------------------------------------------------------------------
  logic [31:0] lane_sh;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_fmt;

  always_comb begin
    lane_sh = bus_rdata >> {r_off, 3'b000};
    ld_b    = lane_sh[7:0];
    ld_h    = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_f3)
      3'b000:  ld_fmt = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_fmt = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_fmt = {24'h0, ld_b};
      3'b101:  ld_fmt = {16'h0, ld_h};
      default: ld_fmt = bus_rdata;
    endcase
  end

  assign busy = (state == BUSY);

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      r_f3      <= '0;
      r_off     <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Bus responses seen while idle are stale and ignored.
          if (req_both) begin
            state <= ERR;
            error <= 1'b1;
          end else if (req_rd | req_wr) begin
            if (req_ok) begin
              state     <= BUSY;
              cnt       <= '0;
              bus_req   <= 1'b1;
              bus_we    <= dec.we;
              bus_addr  <= dec.addr;
              bus_be    <= dec.be;
              bus_wdata <= dec.wdata;
              r_f3      <= dec.f3;
              r_off     <= dec.off;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end

        BUSY: begin
          // New strobes are not looked at here; the control unit is stalled.
          if (bus_err) begin
            // Slave error takes priority over a coincident ack.
            state   <= ERR;
            error   <= 1'b1;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= '0;
          end else if (bus_ack) begin
            state   <= IDLE;
            done    <= 1'b1;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= '0;
            if (!bus_we) rdata <= ld_fmt;
          end else if ((TIMEOUT > 0) && (cnt == TO_LAST)) begin
            // cnt counts completed wait cycles, so this is the last of
            // TIMEOUT request cycles.
            state   <= ERR;
            error   <= 1'b1;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        ERR: begin
          // Sticky until reset; requests and bus responses are dropped.
          error   <= 1'b1;
          bus_req <= 1'b0;
        end

        default: begin
          state <= ERR;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl (TIMEOUT=4). Inputs are driven and
// outputs sampled on the falling edge; expected load results are queued when
// a request is issued and compared when done is observed.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, isInstr;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        busy, done, error;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack, bus_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .memRead(memRead), .memWrite(memWrite), .isInstr(isInstr),
    .addr(addr), .wdata(wdata), .funct3(funct3),
    .rdata(rdata), .busy(busy), .done(done), .error(error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic apply_reset;
    rst = 1'b1;
    memRead = 0; memWrite = 0; isInstr = 0;
    bus_ack = 0; bus_err = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request and complete it after `waits` ack-less cycles.
  // Returns at the falling edge of the cycle in which done should be high.
  task automatic do_txn(input logic rd, input logic wr, input logic instr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] brd,
                        input int waits, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input string name);
    int busy_n;
    logic [31:0] want;
    memRead = rd; memWrite = wr; isInstr = instr;
    addr = a; wdata = wd; funct3 = f3;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    memRead = 0; memWrite = 0; isInstr = 0;
    busy_n = busy ? 1 : 0;
    vectors++;
    if ({bus_req, busy, bus_we, done} !== {1'b1, 1'b1, wr, 1'b0}) begin
      miscompares++;
      $display("FAIL %s start: req/busy/we/done=%b want %b", name,
               {bus_req, busy, bus_we, done}, {1'b1, 1'b1, wr, 1'b0});
    end
    vectors++;
    if (bus_addr !== exp_addr || bus_be !== exp_be) begin
      miscompares++;
      $display("FAIL %s bus: addr=%h be=%b want addr=%h be=%b", name,
               bus_addr, bus_be, exp_addr, exp_be);
    end
    if (wr) begin
      vectors++;
      if (bus_wdata !== exp_wd) begin
        miscompares++;
        $display("FAIL %s wdata: got %h want %h", name, bus_wdata, exp_wd);
      end
    end
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      vectors++;
      if (bus_req !== 1'b1 || bus_addr !== exp_addr || bus_be !== exp_be || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s wait%0d: req=%b addr=%h be=%b done=%b", name, i,
                 bus_req, bus_addr, bus_be, done);
      end
    end
    bus_ack = 1'b1;
    bus_rdata = brd;
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    vectors++;
    if ({done, busy, bus_req, bus_we, bus_be} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
      miscompares++;
      $display("FAIL %s end: done/busy/req/we/be=%b want 10000000", name,
               {done, busy, bus_req, bus_we, bus_be});
    end
    vectors++;
    if (busy_n != waits + 1) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, waits + 1);
    end
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    vectors++;
    if (rdata !== want) begin
      miscompares++;
      $display("FAIL %s rdata: got %h want %h", name, rdata, want);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    memRead = 0; memWrite = 0; isInstr = 0;
    addr = 0; wdata = 0; funct3 = 0;
    bus_ack = 0; bus_err = 0; bus_rdata = 0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({rdata, busy, done, error, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rdata=%h busy=%b done=%b err=%b req=%b we=%b addr=%h be=%b wd=%h",
               rdata, busy, done, error, bus_req, bus_we, bus_addr, bus_be, bus_wdata);
    end
    rst = 1'b0;
    // Bus responses while idle must be ignored.
    bus_ack = 1'b1; bus_err = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0; bus_err = 1'b0;
    vectors++;
    if ({error, done, busy, bus_req} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_ack_err: err/done/busy/req=%b want 0000",
               {error, done, busy, bus_req});
    end
  endtask

  task automatic test_lw_zero_wait;
    do_txn(1, 0, 0, 32'h104, 32'h0, 3'b010, 32'hDEADBEEF, 0,
           32'h104, 4'b1111, 32'h0, 32'hDEADBEEF, "lw_zero_wait");
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lw_done_pulse: done=%b rdata=%h want 0/deadbeef", done, rdata);
    end
  endtask

  task automatic test_lb_lbu;
    do_txn(1, 0, 0, 32'h203, 32'h0, 3'b000, 32'h80FF7F01, 3,
           32'h200, 4'b1000, 32'h0, 32'hFFFFFF80, "lb_wait3");
    @(negedge clk);
    do_txn(1, 0, 0, 32'h203, 32'h0, 3'b100, 32'h80FF7F01, 3,
           32'h200, 4'b1000, 32'h0, 32'h00000080, "lbu_wait3");
    @(negedge clk);
  endtask

  task automatic test_sh;
    do_txn(0, 1, 0, 32'h12, 32'h0000ABCD, 3'b001, 32'h0, 1,
           32'h10, 4'b1100, 32'hABCDABCD, 32'h00000080, "sh_off2");
    @(negedge clk);
  endtask

  task automatic test_sizes;
    do_txn(1, 0, 0, 32'h202, 0, 3'b001, 32'h80FF7F01, 0, 32'h200, 4'b1100, 0, 32'hFFFF80FF, "lh_hi");
    @(negedge clk);
    do_txn(1, 0, 0, 32'h200, 0, 3'b101, 32'h80FF7F01, 1, 32'h200, 4'b0011, 0, 32'h00007F01, "lhu_lo");
    @(negedge clk);
    do_txn(1, 0, 0, 32'h201, 0, 3'b000, 32'h80FF7F01, 0, 32'h200, 4'b0010, 0, 32'h0000007F, "lb_pos");
    @(negedge clk);
    do_txn(1, 0, 0, 32'h202, 0, 3'b000, 32'h80FF7F01, 2, 32'h200, 4'b0100, 0, 32'hFFFFFFFF, "lb_neg");
    @(negedge clk);
    do_txn(0, 1, 0, 32'h1, 32'h12345678, 3'b000, 0, 0, 32'h0, 4'b0010, 32'h78787878, 32'hFFFFFFFF, "sb_off1");
    @(negedge clk);
    do_txn(0, 1, 0, 32'h8, 32'hCAFEF00D, 3'b010, 0, 2, 32'h8, 4'b1111, 32'hCAFEF00D, 32'hFFFFFFFF, "sw");
    @(negedge clk);
    // Fetch with an LHU-looking funct3 must still be a full word.
    do_txn(1, 0, 1, 32'h300, 0, 3'b101, 32'h80000001, 0, 32'h300, 4'b1111, 0, 32'h80000001, "ifetch");
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    do_txn(1, 0, 0, 32'h40, 0, 3'b010, 32'h11111111, 0, 32'h40, 4'b1111, 0, 32'h11111111, "b2b_lw");
    do_txn(0, 1, 0, 32'h44, 32'h22222222, 3'b010, 0, 2, 32'h44, 4'b1111, 32'h22222222, 32'h11111111, "b2b_sw");
    do_txn(1, 0, 0, 32'h45, 0, 3'b100, 32'h0000AB00, 0, 32'h44, 4'b0010, 0, 32'h000000AB, "b2b_lbu");
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_errors;
    logic [1:0]  c_rw  [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    logic [2:0]  c_f3  [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] c_adr [5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h100};
    int req_seen;
    for (int c = 0; c < 5; c++) begin
      apply_reset();
      memRead = c_rw[c][1]; memWrite = c_rw[c][0];
      funct3 = c_f3[c]; addr = c_adr[c]; wdata = 32'h5A5A5A5A;
      @(negedge clk);
      memRead = 0; memWrite = 0;
      vectors++;
      if ({error, bus_req, busy, done} !== 4'b1000) begin
        miscompares++;
        $display("FAIL bad_req%0d: err/req/busy/done=%b want 1000", c,
                 {error, bus_req, busy, done});
      end
      // A valid LW afterwards must be ignored.
      memRead = 1; funct3 = 3'b010; addr = 32'h100;
      req_seen = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        memRead = 0;
        if (bus_req || busy || !error) req_seen++;
      end
      vectors++;
      if (req_seen != 0) begin
        miscompares++;
        $display("FAIL bad_req%0d_sticky: %0d cycles with req/busy or no error, want 0", c, req_seen);
      end
    end
    apply_reset();
    @(negedge clk);
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL err_cleared_by_rst: error=%b want 0", error);
    end
  endtask

  task automatic test_timeout;
    int req_cnt, first_err, unstable, done_seen;
    apply_reset();
    memRead = 1; funct3 = 3'b010; addr = 32'h100;
    req_cnt = 0; first_err = -1; unstable = 0; done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      memRead = 0; memWrite = 0;
      // Stray write strobe while busy must not disturb the bus.
      if (i == 1) begin memWrite = 1; addr = 32'h200; wdata = 32'hFFFFFFFF; end
      if (bus_req) req_cnt++;
      if (bus_req && (bus_addr !== 32'h100 || bus_we !== 1'b0)) unstable++;
      if (error && first_err < 0) first_err = i;
      if (done) done_seen++;
    end
    memWrite = 0;
    vectors++;
    if (req_cnt != 4 || first_err != 4) begin
      miscompares++;
      $display("FAIL timeout: req cycles %0d err at %0d, want 4 and 4", req_cnt, first_err);
    end
    vectors++;
    if (unstable != 0 || done_seen != 0) begin
      miscompares++;
      $display("FAIL timeout_stable: unstable=%0d done=%0d want 0/0", unstable, done_seen);
    end
  endtask

  task automatic test_ack_err;
    apply_reset();
    memRead = 1; funct3 = 3'b010; addr = 32'h100;
    @(negedge clk);
    memRead = 0;
    bus_ack = 1; bus_err = 1; bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_ack = 0; bus_err = 0;
    vectors++;
    if ({error, done, busy, bus_req} !== 4'b1000 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL ack_err: err/done/busy/req=%b rdata=%h want 1000/0",
               {error, done, busy, bus_req}, rdata);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    apply_reset();
    do_txn(1, 0, 0, 32'h10, 0, 3'b010, 32'h55AA55AA, 0, 32'h10, 4'b1111, 0, 32'h55AA55AA, "pre_rst_lw");
    @(negedge clk);
    memRead = 1; funct3 = 3'b010; addr = 32'h20;
    @(negedge clk);
    memRead = 0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_busy: busy=%b want 1", busy);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    bus_ack = 1; bus_rdata = 32'h99999999;
    vectors++;
    if ({rdata, busy, done, error, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: rdata=%h busy=%b done=%b req=%b be=%b",
               rdata, busy, done, bus_req, bus_be);
    end
    @(negedge clk);
    bus_ack = 0;
    bad = (done !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) ? 1 : 0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rst_mid_late_ack: done=%b req=%b busy=%b rdata=%h want all 0",
               done, bus_req, busy, rdata);
    end
    do_txn(1, 0, 0, 32'h30, 0, 3'b010, 32'h01020304, 1, 32'h30, 4'b1111, 0, 32'h01020304, "post_rst_lw");
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_lb_lbu();
    test_sh();
    test_sizes();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_ack_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
